// File: rtl/pipeline_ctrl_if.sv
// Pipeline-control bundle: stage stall requests, exception commit and perf clear in;
// stall/flush/redirect, watchdog and perf count out.
interface pipeline_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        excp_valid_i;
  logic        excp_eret_i;
  logic [31:0] cp0_epc_i;
  logic        perf_clr_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  // master: the pipeline side raising requests; slave: the controller
  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
           excp_valid_i, excp_eret_i, cp0_epc_i, perf_clr_i,
    input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
           excp_valid_i, excp_eret_i, cp0_epc_i, perf_clr_i,
    output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 6-stage pipeline with stall watchdog.
// Optional stall-cycle counter enabled by defining STALL_PERF_EN.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          WD_W          = 11
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       new_pc_reg, new_pc_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              timeout_reg, timeout_next;
  logic [5:0]        req_mask;
  logic [5:0]        stall_comb;

  // Highest requesting stage holds itself and everything upstream of it
  always_comb begin
    req_mask = 6'b000000;
    if (bus.stallreq_mem_i)     req_mask = 6'b011111;
    else if (bus.stallreq_ex_i) req_mask = 6'b001111;
    else if (bus.stallreq_id_i) req_mask = 6'b000111;
    else if (bus.stallreq_if_i) req_mask = 6'b000011;
  end

  always_comb begin
    state_next   = state_reg;
    new_pc_next  = new_pc_reg;
    stall_comb   = 6'b000000;
    wd_next      = wd_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      RUN: begin
        if (rst) stall_comb = req_mask;
        if (bus.excp_valid_i) begin
          state_next  = FLUSH;
          new_pc_next = bus.excp_eret_i ? bus.cp0_epc_i : EXC_VECTOR;
        end
      end
      FLUSH: state_next = RUN;
      default: state_next = RUN;
    endcase

    // Watchdog: the flush restarts the count; the timeout flag only drops once the stall releases
    if (!stall_comb[0]) begin
      wd_next      = '0;
      timeout_next = 1'b0;
    end else if (state_next == FLUSH) begin
      wd_next = '0;
    end else if (wd_reg >= WD_W'(STALL_TIMEOUT - 1)) begin
      wd_next      = WD_W'(STALL_TIMEOUT);
      timeout_next = 1'b1;
    end else begin
      wd_next = wd_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      new_pc_reg  <= 32'h0;
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      new_pc_reg  <= new_pc_next;
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.stall_o         = stall_comb;
  assign bus.flush_o         = (state_reg == FLUSH);
  assign bus.new_pc_o        = new_pc_reg;
  assign bus.stall_timeout_o = timeout_reg;

`ifdef STALL_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   perf_reg <= 32'h0;
    else if (bus.perf_clr_i)    perf_reg <= 32'h0;
    else if (stall_comb != '0)  perf_reg <= perf_reg + 32'h1;
  end

  assign bus.stall_cycles_o = perf_reg;
`else
  logic unused_perf_clr;
  assign unused_perf_clr    = bus.perf_clr_i;
  assign bus.stall_cycles_o = 32'h0;
`endif

endmodule
